// File: rtl/framemem_pkg.sv
// rtl/framemem_pkg.sv - shared frame-memory types and default geometry
package framemem_pkg;

  localparam int FM_DATA_WIDTH = 96;
  localparam int FM_ADDR_DEPTH = 512 * 512 / 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_BURST = 2'd2
  } fm_state_t;

  typedef enum logic {
    WR = 1'b0,
    RD = 1'b1
  } fm_req_id_t;

endpackage

// File: rtl/framemem_arbiter.sv
// rtl/framemem_arbiter.sv - bursting two-way write/read arbiter in front of a single-port frame SRAM
module framemem_arbiter
  import framemem_pkg::*;
#(
  parameter int DATA_WIDTH = FM_DATA_WIDTH,
  parameter int ADDR_DEPTH = FM_ADDR_DEPTH,
  parameter int ADDR_WIDTH = $clog2(ADDR_DEPTH),
  parameter int BURST_LEN  = 8
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_gnt,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_gnt,
  output logic                  rd_rvalid,
  output logic [DATA_WIDTH-1:0] rd_rdata,
  output logic                  MEM_CSN,
  output logic                  MEM_WEN,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  output logic [DATA_WIDTH-1:0] MEM_DIN,
  input  logic [DATA_WIDTH-1:0] MEM_DOUT
);

  localparam int CW = $clog2(BURST_LEN + 1);

  fm_state_t  state, state_nxt;
  fm_req_id_t last_served, last_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic wr_pick, rd_pick;

  always_comb begin
    wr_pick   = 1'b0;
    rd_pick   = 1'b0;
    state_nxt = IDLE;
    cnt_nxt   = '0;
    last_nxt  = last_served;
    if (state == WR_BURST && wr_req) begin
      wr_pick   = 1'b1;
      state_nxt = WR_BURST;
      cnt_nxt   = cnt + 1'b1;
    end else if (state == RD_BURST && rd_req) begin
      rd_pick   = 1'b1;
      state_nxt = RD_BURST;
      cnt_nxt   = cnt + 1'b1;
    end else begin
      // An owner that let go counts as served, then arbitrate in this same cycle
      if (state == WR_BURST) last_nxt = WR;
      else if (state == RD_BURST) last_nxt = RD;
      if (wr_req && (!rd_req || last_nxt == RD)) begin
        wr_pick   = 1'b1;
        state_nxt = WR_BURST;
        cnt_nxt   = CW'(1);
      end else if (rd_req) begin
        rd_pick   = 1'b1;
        state_nxt = RD_BURST;
        cnt_nxt   = CW'(1);
      end
    end
    if ((wr_pick || rd_pick) && cnt_nxt == CW'(BURST_LEN)) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      last_nxt  = wr_pick ? WR : RD;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state       <= IDLE;
      cnt         <= '0;
      last_served <= RD;
      rd_rvalid   <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      last_served <= last_nxt;
      rd_rvalid   <= rd_gnt;
    end
  end

  // Grants are combinational, so they must be masked while reset is held
  assign wr_gnt   = wr_pick & RSTN;
  assign rd_gnt   = rd_pick & RSTN;
  assign rd_rdata = MEM_DOUT;

  always_comb begin
    MEM_CSN  = 1'b1;
    MEM_WEN  = 1'b1;
    MEM_ADDR = '0;
    MEM_DIN  = '0;
    if (wr_gnt) begin
      MEM_CSN  = 1'b0;
      MEM_WEN  = 1'b0;
      MEM_ADDR = wr_addr;
      MEM_DIN  = wr_data;
    end else if (rd_gnt) begin
      MEM_CSN  = 1'b0;
      MEM_ADDR = rd_addr;
    end
  end

endmodule

// File: tb/tb_framemem_arbiter.sv
// tb/tb_framemem_arbiter.sv - randomized reference-model bench for framemem_arbiter
module tb_framemem_arbiter;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic w4 = 1'b0, r4 = 1'b0, w1 = 1'b0, r1 = 1'b0;
  logic [3:0] wa = '0, ra = '0;
  logic [95:0] wd = '0;

  logic wg4, rg4, rv4, csn4, wen4;
  logic [3:0] maddr4;
  logic [95:0] din4, dout4, rdata4;
  logic wg1, rg1, rv1, csn1, wen1;
  logic [3:0] maddr1;
  logic [95:0] din1, dout1, rdata1;

  logic [95:0] sram4 [16];
  logic [95:0] sram1 [16];

  int n_checks = 0;
  int n_errors = 0;

  int own  [2];
  int cnt  [2];
  int last [2];
  int blen [2] = '{4, 1};
  bit exp_rv [2];
  bit exp_ok [2];
  logic [95:0] exp_rd [2];
  logic [95:0] refm [2][16];
  bit refv [2][16];

  bit obs_wg [2];
  bit obs_rg [2];
  bit obs_rv [2];
  logic [95:0] obs_rd [2];

  localparam logic [95:0] PATTERN = 96'h0123_4567_89AB_CDEF_0011_2233;

  always #5 clk = ~clk;

  framemem_arbiter #(.DATA_WIDTH(96), .ADDR_DEPTH(16), .BURST_LEN(4)) dut4 (
    .CLK(clk), .RSTN(rstn),
    .wr_req(w4), .wr_addr(wa), .wr_data(wd), .wr_gnt(wg4),
    .rd_req(r4), .rd_addr(ra), .rd_gnt(rg4), .rd_rvalid(rv4), .rd_rdata(rdata4),
    .MEM_CSN(csn4), .MEM_WEN(wen4), .MEM_ADDR(maddr4), .MEM_DIN(din4), .MEM_DOUT(dout4)
  );

  framemem_arbiter #(.DATA_WIDTH(96), .ADDR_DEPTH(16), .BURST_LEN(1)) dut1 (
    .CLK(clk), .RSTN(rstn),
    .wr_req(w1), .wr_addr(wa), .wr_data(wd), .wr_gnt(wg1),
    .rd_req(r1), .rd_addr(ra), .rd_gnt(rg1), .rd_rvalid(rv1), .rd_rdata(rdata1),
    .MEM_CSN(csn1), .MEM_WEN(wen1), .MEM_ADDR(maddr1), .MEM_DIN(din1), .MEM_DOUT(dout1)
  );

  always @(posedge clk) begin
    if (!csn4) begin
      if (!wen4) sram4[maddr4] <= din4;
      else dout4 <= sram4[maddr4];
    end
    if (!csn1) begin
      if (!wen1) sram1[maddr1] <= din1;
      else dout1 <= sram1[maddr1];
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Owner keeps the SRAM while asking, up to blen beats; otherwise the one served less recently wins
  task automatic model(input int k, input bit w, input bit r, output bit gw, output bit gr);
    int g;
    g = 0;
    if (own[k] == 1 && w) g = 1;
    else if (own[k] == 2 && r) g = 2;
    else begin
      if (own[k] != 0) last[k] = own[k];
      own[k] = 0;
      cnt[k] = 0;
      if (w && r) g = (last[k] == 1) ? 2 : 1;
      else if (w) g = 1;
      else if (r) g = 2;
      own[k] = g;
    end
    if (g != 0) begin
      cnt[k]++;
      if (cnt[k] == blen[k]) begin
        last[k] = g;
        own[k] = 0;
        cnt[k] = 0;
      end
    end
    gw = (g == 1);
    gr = (g == 2);
  endtask

  task automatic check_dut(input int k, input bit gw, input bit gr,
                           input logic wg, input logic rg, input logic rv,
                           input logic csn, input logic wen,
                           input logic [3:0] ma, input logic [95:0] di, input logic [95:0] rdt);
    string p;
    p = (k == 0) ? "b4_" : "b1_";
    check({p, "wr_gnt"}, wg, gw);
    check({p, "rd_gnt"}, rg, gr);
    check({p, "one_gnt"}, wg & rg, 1'b0);
    check({p, "rvalid"}, rv, exp_rv[k]);
    if (exp_rv[k] && exp_ok[k]) check({p, "rdata"}, rdt, exp_rd[k]);
    check({p, "csn"}, csn, !(gw || gr));
    check({p, "wen"}, wen, !gw);
    if (gw) begin
      check({p, "addr_wr"}, ma, wa);
      check({p, "din_wr"}, di, wd);
    end else if (gr) begin
      check({p, "addr_rd"}, ma, ra);
    end else begin
      check({p, "addr_idle"}, ma, 4'd0);
      check({p, "din_idle"}, di, 96'd0);
    end
    obs_wg[k] = wg;
    obs_rg[k] = rg;
    obs_rv[k] = rv;
    obs_rd[k] = rdt;
    exp_rv[k] = gr;
    exp_rd[k] = refm[k][ra];
    exp_ok[k] = refv[k][ra];
    if (gw) begin
      refm[k][wa] = wd;
      refv[k][wa] = 1'b1;
    end
  endtask

  task automatic cycle(input bit a4, input bit b4, input bit a1, input bit b1,
                       input logic [3:0] wadr, input logic [3:0] radr, input logic [95:0] wdat);
    bit gw, gr;
    w4 = a4; r4 = b4; w1 = a1; r1 = b1;
    wa = wadr; ra = radr; wd = wdat;
    @(negedge clk);
    model(0, a4, b4, gw, gr);
    check_dut(0, gw, gr, wg4, rg4, rv4, csn4, wen4, maddr4, din4, rdata4);
    model(1, a1, b1, gw, gr);
    check_dut(1, gw, gr, wg1, rg1, rv1, csn1, wen1, maddr1, din1, rdata1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    w4 = 1'b1; r4 = 1'b1; w1 = 1'b1; r1 = 1'b1;
    wa = 4'd3; ra = 4'd7; wd = 96'hA5;
    #1;
    check("rst_rvalid_now_b4", rv4, 1'b0);
    check("rst_rvalid_now_b1", rv1, 1'b0);
    check("rst_csn_now_b4", csn4, 1'b1);
    @(negedge clk);
    check("rst_wr_gnt", {wg4, wg1}, 2'b00);
    check("rst_rd_gnt", {rg4, rg1}, 2'b00);
    check("rst_rvalid", {rv4, rv1}, 2'b00);
    check("rst_csn_wen", {csn4, wen4, csn1, wen1}, 4'b1111);
    check("rst_addr", {maddr4, maddr1}, 8'd0);
    check("rst_din", din4 | din1, 96'd0);
    for (int k = 0; k < 2; k++) begin
      own[k] = 0;
      cnt[k] = 0;
      last[k] = 2;
      exp_rv[k] = 1'b0;
      exp_ok[k] = 1'b0;
    end
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 16; a++) refv[k][a] = 1'b0;
    do_reset();

    // Write then read back address 5
    cycle(1, 0, 0, 0, 4'd5, 4'd0, PATTERN);
    cycle(0, 1, 0, 0, 4'd9, 4'd5, 96'hDEAD);
    check("rw_rd_gnt", obs_rg[0], 1'b1);
    cycle(0, 0, 0, 0, 4'd0, 4'd0, 96'd0);
    check("rw_rvalid", obs_rv[0], 1'b1);
    check("rw_rdata", obs_rd[0], PATTERN);

    // Continuous contention from reset release: 4-beat bursts and strict alternation
    do_reset();
    for (int i = 0; i < 12; i++) begin
      cycle(1, 1, 1, 1, 4'(i), 4'(i + 3), {3{$urandom}});
      check("burst4_wr", obs_wg[0], (i < 4 || i >= 8));
      check("burst4_rd", obs_rg[0], (i >= 4 && i < 8));
      check("burst1_wr", obs_wg[1], (i % 2 == 0));
      check("burst1_rvalid", obs_rv[1], (i % 2 == 0 && i > 0));
    end

    // Writer drops mid-burst: reader takes over with no bubble, then writer wins next contention
    do_reset();
    cycle(1, 1, 0, 0, 4'd1, 4'd2, 96'h11);
    cycle(1, 1, 0, 0, 4'd2, 4'd2, 96'h22);
    cycle(0, 1, 0, 0, 4'd3, 4'd2, 96'h33);
    check("handoff_rd_gnt", obs_rg[0], 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 1, 0, 0, 4'd4, 4'd1, 96'h44);
      check("handoff_rd_burst", obs_rg[0], 1'b1);
    end
    cycle(1, 1, 0, 0, 4'd4, 4'd1, 96'h55);
    check("handoff_wr_next", obs_wg[0], 1'b1);

    // Reset right after a read transfer
    cycle(0, 1, 0, 1, 4'd0, 4'd4, 96'h0);
    do_reset();
    cycle(1, 1, 1, 1, 4'd6, 4'd6, 96'h66);
    check("post_rst_wr_first", {obs_wg[0], obs_wg[1]}, 2'b11);

    for (int i = 0; i < 1000; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            {$urandom, $urandom, $urandom});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/framemem_arbiter.md
FRAMEMEM_ARBITER -- requirements
Module: framemem_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 96, giving the SRAM word width in bits (four packed 24-bit pixels).
REQ-002 The block SHALL have parameter ADDR_DEPTH, default 512*512/4, giving the number of SRAM words.
REQ-003 The block SHALL have parameter ADDR_WIDTH, default $clog2(ADDR_DEPTH), giving the SRAM address width.
REQ-004 The block SHALL have parameter BURST_LEN, default 8, giving the maximum number of consecutive grants to one requester while the other requester waits.
REQ-005 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port RSTN, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have write-requester ports wr_req (in, 1), wr_addr (in, ADDR_WIDTH), wr_data (in, DATA_WIDTH) and wr_gnt (out, 1).
REQ-008 The block SHALL have read-requester ports rd_req (in, 1), rd_addr (in, ADDR_WIDTH), rd_gnt (out, 1), rd_rvalid (out, 1) and rd_rdata (out, DATA_WIDTH).
REQ-009 The block SHALL have SRAM-side ports MEM_CSN (out, 1, active-low select), MEM_WEN (out, 1, 0 = write), MEM_ADDR (out, ADDR_WIDTH), MEM_DIN (out, DATA_WIDTH) and MEM_DOUT (in, DATA_WIDTH, registered read data valid one cycle after a read select).

Function
REQ-010 A transfer SHALL occur in any cycle where req and gnt of the same requester are both 1; wr_gnt and rd_gnt SHALL never both be 1.
REQ-011 wr_gnt and rd_gnt SHALL be combinational from the state, the last-served flag, wr_req and rd_req; a grant SHALL only be asserted while the matching req is 1.
REQ-012 On a write transfer, in the same cycle, the outputs SHALL be MEM_CSN=0, MEM_WEN=0, MEM_ADDR=wr_addr, MEM_DIN=wr_data.
REQ-013 On a read transfer, in the same cycle, the outputs SHALL be MEM_CSN=0, MEM_WEN=1, MEM_ADDR=rd_addr.
REQ-014 On a cycle with no transfer, the outputs SHALL be MEM_CSN=1, MEM_WEN=1, with MEM_ADDR and MEM_DIN at 0.
REQ-015 rd_rvalid SHALL be a register set to 1 in the cycle after each read transfer and 0 otherwise; rd_rdata SHALL equal MEM_DOUT, giving a fixed read latency of 1 cycle.
REQ-016 The FSM SHALL have states IDLE, WR_BURST and RD_BURST, plus a beat counter of width $clog2(BURST_LEN+1) and a last_served flag (WR/RD).
REQ-017 In IDLE, if only one requester is requesting, that requester SHALL be granted; if both are requesting, the requester not equal to last_served SHALL be granted; if neither is requesting, no grant SHALL be given.
REQ-018 In IDLE, a grant SHALL move the FSM to the matching burst state with the counter set to 1.
REQ-019 In WR_BURST or RD_BURST, if the owner's req is 1 the owner SHALL be granted and the counter incremented.
REQ-020 In a burst state, if the owner's req is 0, the IDLE arbitration SHALL be applied in the same cycle, with no bubble cycle.
REQ-021 When an owner grant brings the counter to BURST_LEN, the next state SHALL be IDLE and last_served SHALL be set to the owner.
REQ-022 When the owner's req is 0 in a burst state, last_served SHALL be set to the owner before re-arbitration.
REQ-023 With BURST_LEN=1, grants SHALL alternate every cycle under continuous dual requests.
REQ-024 A requester changing its addr or data while req=1 and gnt=0 SHALL have no effect; the block SHALL hold no request data.

Reset
REQ-025 While RSTN=0, the outputs SHALL be wr_gnt=0, rd_gnt=0, rd_rvalid=0, MEM_CSN=1, MEM_WEN=1, MEM_ADDR=0 and MEM_DIN=0.
REQ-026 While RSTN=0, the state SHALL be IDLE, the counter SHALL be 0 and last_served SHALL be RD, so the first contended grant goes to WR.
REQ-027 Reset asserted mid-burst SHALL abandon the burst; a pending rd_rvalid SHALL be cleared, and nothing SHALL be replayed after reset.

Structure
REQ-028 The state enum (IDLE, WR_BURST, RD_BURST), the requester-ID type (WR/RD) and the DATA_WIDTH/ADDR_DEPTH defaults SHALL be placed in the shared package framemem_pkg, also used by FRAMEMEM instances.
REQ-029 The block SHALL be a single module with no sub-module; the two-way arbitration SHALL be inline logic.

Verification
REQ-030 After reset, a write of 96'h0123_4567_89AB_CDEF_0011_2233 at address 5, followed by a read of address 5, SHALL give rd_gnt in cycle t, then rd_rvalid=1 in cycle t+1 with rd_rdata=96'h0123_4567_89AB_CDEF_0011_2233.
REQ-031 With BURST_LEN=4 and wr_req and rd_req both held at 1 from reset release, the grants SHALL follow the pattern WR x4, RD x4, WR x4, with no idle cycle and no dual grant.
REQ-032 With BURST_LEN=4, if wr_req drops after the 2nd WR beat while rd_req=1, rd_gnt SHALL be 1 in the same cycle; a later contended arbitration SHALL grant WR first (last_served=RD after that RD burst).
REQ-033 With BURST_LEN=1 and both requesters held, grants SHALL alternate WR, RD, WR, RD, and rd_rvalid SHALL pulse one cycle after each RD grant.
REQ-034 RSTN asserted in the cycle after a read transfer SHALL give rd_rvalid=0 immediately, MEM_CSN=1 and state IDLE.
REQ-035 The bench SHALL run a scoreboard against an FRAMEMEM model over 1000 random req/addr cycles: every read SHALL return the last data written to that address, and at most one grant SHALL be asserted in any cycle.
